// File: rtl/if_stage_pkg.sv
// Shared types for the instruction-fetch stage: FSM states, reset PC and
// the IF/ID pipeline register layout.
package if_types;

    typedef enum logic [1:0] {
        FETCH,
        HOLD,
        DROP
    } if_state_e;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0060;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
    } ifid_reg_t;

    // Sequential PC; wraps modulo 2^32.
    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/if_stage_if.sv
// Instruction-memory read handshake between the fetch stage (master) and
// the I-cache (slave). resp is a single-cycle pulse; rdata is valid with it.
interface if_stage_if;

    logic        read;
    logic [31:0] address;
    logic        resp;
    logic [31:0] rdata;

    modport master (
        output read,
        output address,
        input  resp,
        input  rdata
    );

    modport slave (
        input  read,
        input  address,
        output resp,
        output rdata
    );

endinterface

// File: rtl/if_stage_pc_register.sv
// Loadable 32-bit register holding the fetch PC, with a configurable
// reset value.
module pc_register #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // Synchronous reset; otherwise update only when load is asserted.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= RESET_VALUE;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage of the rv32i pipeline. Owns the PC, drives the
// I-cache read handshake, holds a one-entry skid buffer for responses that
// arrive while decode is stalled, and contains the IF/ID register.
// Optional build macro IF_PERF_CNT_EN adds saturating performance counters
// perf_fetched and perf_imem_wait.
module if_stage
    import if_types::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_target,
    if_stage_if.master  imem,
    output logic [31:0] ifid_instruction,
    output logic [31:0] ifid_pc,
    output logic        ifid_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_imem_wait
`endif
);

    if_state_e   state, state_next;
    logic [31:0] pc, pc_next;
    logic        pc_load;
    ifid_reg_t   ifid, ifid_next;
    ifid_reg_t   skid, skid_next;
    logic [31:0] pending_pc, pending_next;
    logic        accept;
    logic        ifid_fill;

    assign accept = !id_stall;

    pc_register #(
        .RESET_VALUE(PC_RESET)
    ) u_pc (
        .clk (clk),
        .rst (rst),
        .load(pc_load),
        .d   (pc_next),
        .q   (pc)
    );

    // The address stays at pc in DROP, so an abandoned request stays stable.
    assign imem.read    = !rst && (state != HOLD);
    assign imem.address = pc;

    assign ifid_instruction = ifid.instr;
    assign ifid_pc          = ifid.pc;
    assign ifid_valid       = ifid.valid;

    // Next-state, PC update and IF/ID / skid buffer loading.
    always_comb begin
        state_next   = state;
        pc_load      = 1'b0;
        pc_next      = pc;
        skid_next    = skid;
        pending_next = pending_pc;
        ifid_fill    = 1'b0;
        ifid_next    = ifid;
        // Decode advancing with nothing new to give it sees a bubble.
        if (accept) begin
            ifid_next.valid = 1'b0;
        end

        case (state)
            FETCH: begin
                if (imem.resp) begin
                    if (ex_redirect) begin
                        pc_load = 1'b1;
                        pc_next = ex_target;
                    end else if (accept) begin
                        ifid_next = '{instr: imem.rdata, pc: pc, valid: 1'b1};
                        ifid_fill = 1'b1;
                        pc_load   = 1'b1;
                        pc_next   = pc_plus4(pc);
                    end else begin
                        skid_next  = '{instr: imem.rdata, pc: pc, valid: 1'b1};
                        state_next = HOLD;
                    end
                end else if (ex_redirect) begin
                    // Cannot cancel the outstanding request; wait it out.
                    pending_next = ex_target;
                    state_next   = DROP;
                end
            end
            HOLD: begin
                if (ex_redirect) begin
                    skid_next.valid = 1'b0;
                    pc_load         = 1'b1;
                    pc_next         = ex_target;
                    state_next      = FETCH;
                end else if (accept) begin
                    ifid_next       = skid;
                    ifid_fill       = 1'b1;
                    skid_next.valid = 1'b0;
                    pc_load         = 1'b1;
                    pc_next         = pc_plus4(pc);
                    state_next      = FETCH;
                end
            end
            DROP: begin
                if (imem.resp) begin
                    pc_load    = 1'b1;
                    pc_next    = ex_redirect ? ex_target : pending_pc;
                    state_next = FETCH;
                end else if (ex_redirect) begin
                    pending_next = ex_target;
                end
            end
            default: begin
                state_next = FETCH;
            end
        endcase

        // A redirect flushes IF/ID even when decode is stalled.
        if (ex_redirect) begin
            ifid_next.valid = 1'b0;
            ifid_fill       = 1'b0;
        end
    end

    // State, IF/ID, skid buffer and pending redirect registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= FETCH;
            ifid       <= '0;
            skid       <= '0;
            pending_pc <= '0;
        end else begin
            state      <= state_next;
            ifid       <= ifid_next;
            skid       <= skid_next;
            pending_pc <= pending_next;
        end
    end

`ifdef IF_PERF_CNT_EN
    // Saturating counters of delivered instructions and memory wait cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched   <= '0;
            perf_imem_wait <= '0;
        end else begin
            if (ifid_fill && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (imem.read && !imem.resp && (perf_imem_wait != 32'hFFFF_FFFF)) begin
                perf_imem_wait <= perf_imem_wait + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed, table-driven testbench for if_stage. Each row drives one cycle:
// imem handshake outputs are checked before the edge, IF/ID after it.
module tb_if_stage;

    logic        clk;
    logic        rst;
    logic        id_stall;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic [31:0] ifid_instruction;
    logic [31:0] ifid_pc;
    logic        ifid_valid;
`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_imem_wait;
`endif

    int tests;
    int fails;

    if_stage_if imem_bus ();

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .id_stall        (id_stall),
        .ex_redirect     (ex_redirect),
        .ex_target       (ex_target),
        .imem            (imem_bus),
        .ifid_instruction(ifid_instruction),
        .ifid_pc         (ifid_pc),
        .ifid_valid      (ifid_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_imem_wait  (perf_imem_wait)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        resp;
        logic [31:0] rdata;
        logic        e_read;
        logic        chk_addr;
        logic [31:0] e_addr;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic [31:0] r, s, rd, tg, rs, da,
                               input logic [31:0] er, ca, ea, ev, ep, ei);
        vec_t t;
        t.rst = r[0];   t.stall = s[0];     t.redir = rd[0]; t.target = tg;
        t.resp = rs[0]; t.rdata = da;       t.e_read = er[0]; t.chk_addr = ca[0];
        t.e_addr = ea;  t.e_valid = ev[0];  t.e_pc = ep;      t.e_instr = ei;
        return t;
    endfunction

    task automatic chk(input string nm, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
        end
    endtask

    task automatic step(input vec_t t, input int row);
        @(negedge clk);
        rst           = t.rst;
        id_stall      = t.stall;
        ex_redirect   = t.redir;
        ex_target     = t.target;
        imem_bus.resp  = t.resp;
        imem_bus.rdata = t.rdata;
        #1;
        chk("imem_read", row, {31'd0, imem_bus.read}, {31'd0, t.e_read});
        if (t.chk_addr) chk("imem_address", row, imem_bus.address, t.e_addr);
        @(posedge clk);
        #1;
        chk("ifid_valid", row, {31'd0, ifid_valid}, {31'd0, t.e_valid});
        if (t.e_valid || t.rst) begin
            chk("ifid_pc", row, ifid_pc, t.e_pc);
            chk("ifid_instruction", row, ifid_instruction, t.e_instr);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1; id_stall = 1'b0; ex_redirect = 1'b0; ex_target = '0;
        imem_bus.resp = 1'b0; imem_bus.rdata = '0;

        //        rst stl red target       rsp rdata          rd ca addr        v  pc           instr
        // Zero-wait hits from reset
        vq.push_back(v(1, 0, 0, 'h0,         0, 'h0,          0, 0, 'h0,        0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h13,         1, 1, 'h60,       1, 'h60,       'h13));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h13,         1, 1, 'h64,       1, 'h64,       'h13));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h13,         1, 1, 'h68,       1, 'h68,       'h13));
        // Miss with 3 wait cycles
        vq.push_back(v(1, 0, 0, 'h0,         0, 'h0,          0, 0, 'h0,        0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          1, 1, 'h60,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          1, 1, 'h60,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          1, 1, 'h60,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00100093,   1, 1, 'h60,       1, 'h60,       'h00100093));
        // Response under a 2-cycle stall goes through the skid buffer
        vq.push_back(v(0, 1, 0, 'h0,         1, 'h00200113,   1, 1, 'h64,       1, 'h60,       'h00100093));
        vq.push_back(v(0, 1, 0, 'h0,         0, 'h0,          0, 0, 'h0,        1, 'h60,       'h00100093));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          0, 0, 'h0,        1, 'h64,       'h00200113));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00300193,   1, 1, 'h68,       1, 'h68,       'h00300193));
        // Redirect coincident with a hit drops the data
        vq.push_back(v(0, 0, 1, 'h80,        1, 'hDEADBEEF,   1, 1, 'h6C,       0, 'h0,        'h0));
        // Redirect to 0x200 mid-miss at 0x80
        vq.push_back(v(0, 0, 1, 'h200,       0, 'h0,          1, 1, 'h80,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          1, 1, 'h80,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'hBAD0BAD0,   1, 1, 'h80,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00400213,   1, 1, 'h200,      1, 'h200,      'h00400213));
        // Two redirects in DROP; latest wins
        vq.push_back(v(0, 0, 1, 'h300,       0, 'h0,          1, 1, 'h204,      0, 'h0,        'h0));
        vq.push_back(v(0, 1, 1, 'h400,       0, 'h0,          1, 1, 'h204,      0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'hBAD0BAD1,   1, 1, 'h204,      0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00500293,   1, 1, 'h400,      1, 'h400,      'h00500293));
        // Redirect in the same cycle as the DROP response
        vq.push_back(v(0, 0, 1, 'h500,       0, 'h0,          1, 1, 'h404,      0, 'h0,        'h0));
        vq.push_back(v(0, 0, 1, 'h600,       1, 'hBAD0BAD2,   1, 1, 'h404,      0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00600313,   1, 1, 'h600,      1, 'h600,      'h00600313));
        // Redirect in HOLD flushes valid IF/ID despite stall
        vq.push_back(v(0, 1, 0, 'h0,         1, 'hBAD0BAD3,   1, 1, 'h604,      1, 'h600,      'h00600313));
        vq.push_back(v(0, 1, 1, 'h700,       0, 'h0,          0, 0, 'h0,        0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00700393,   1, 1, 'h700,      1, 'h700,      'h00700393));
        // Stall while waiting, then response while stalled
        vq.push_back(v(0, 1, 0, 'h0,         0, 'h0,          1, 1, 'h704,      1, 'h700,      'h00700393));
        vq.push_back(v(0, 1, 0, 'h0,         1, 'h00800413,   1, 1, 'h704,      1, 'h700,      'h00700393));
        vq.push_back(v(0, 0, 0, 'h0,         0, 'h0,          0, 0, 'h0,        1, 'h704,      'h00800413));
        // Reset during HOLD discards the buffer
        vq.push_back(v(0, 1, 0, 'h0,         1, 'h00900493,   1, 1, 'h708,      1, 'h704,      'h00800413));
        vq.push_back(v(1, 1, 0, 'h0,         0, 'h0,          0, 0, 'h0,        0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h13,         1, 1, 'h60,       1, 'h60,       'h13));
        // PC wraps from 0xFFFFFFFC to 0
        vq.push_back(v(0, 0, 1, 'hFFFFFFFC,  1, 'hBAD0BAD4,   1, 1, 'h64,       0, 'h0,        'h0));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00A00513,   1, 1, 'hFFFFFFFC, 1, 'hFFFFFFFC, 'h00A00513));
        vq.push_back(v(0, 0, 0, 'h0,         1, 'h00B00593,   1, 1, 'h0,        1, 'h0,        'h00B00593));

        foreach (vq[i]) step(vq[i], i);

        // Reset while a miss is outstanding abandons it; refetch starts at 0x60.
        step(v(0, 0, 0, 'h0, 0, 'h0,        1, 1, 'h4,  0, 'h0,  'h0), 100);
        step(v(1, 0, 0, 'h0, 0, 'h0,        0, 0, 'h0,  0, 'h0,  'h0), 101);
        step(v(0, 0, 0, 'h0, 1, 'h00C00613, 1, 1, 'h60, 1, 'h60, 'h00C00613), 102);

`ifdef IF_PERF_CNT_EN
        // Counters: one reset, three wait cycles, one delivered instruction.
        step(v(1, 0, 0, 'h0, 0, 'h0,        0, 0, 'h0,  0, 'h0,  'h0), 200);
        chk("perf_fetched_rst", 200, perf_fetched, 32'd0);
        chk("perf_imem_wait_rst", 200, perf_imem_wait, 32'd0);
        for (int k = 0; k < 3; k++) begin
            step(v(0, 0, 0, 'h0, 0, 'h0,    1, 1, 'h60, 0, 'h0,  'h0), 201 + k);
        end
        step(v(0, 0, 0, 'h0, 1, 'h13,       1, 1, 'h60, 1, 'h60, 'h13), 204);
        chk("perf_fetched", 204, perf_fetched, 32'd1);
        chk("perf_imem_wait", 204, perf_imem_wait, 32'd3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
